// File: rtl/ctrl_pkg.sv
// Shared types, opcodes, encodings and the state-to-output decode for control_unit.
// Latency: none (types and a combinational helper only).
// Backpressure: none. Exception outputs depend on CTRL_EXCEPTION_EN.
package ctrl_pkg;

  localparam int WAIT_W = 3;

  typedef enum logic [4:0] {
    RESET, FETCH, FETCH_WAIT, IR_LOAD, DECODE,
    R_EXEC, R_WB,
    MEM_ADDR, MEM_READ, MEM_WAIT, MEM_WB, MEM_WRITE,
    BRANCH, JUMP, ADDI_EXEC, ADDI_WB, ILLEGAL
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_EXC    = 2'b11;

  typedef struct packed {
    logic       epc_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_out_t;

  // Moore decode: every field defaults to 0, each state raises only what it needs.
  function automatic ctrl_out_t state_outputs(input state_t s);
    ctrl_out_t o;
    o = '0;
    case (s)
      FETCH:     begin o.alu_src_b = SRCB_FOUR; o.alu_op = ALU_ADD; end
      IR_LOAD:   begin o.ir_write = 1'b1; o.pc_write = 1'b1;
                       o.pc_source = PCSRC_ALU; o.alu_src_b = SRCB_FOUR; end
      DECODE:    begin o.alu_src_b = SRCB_IMM_SH2; o.alu_op = ALU_ADD; end
      R_EXEC:    begin o.alu_src_a = 1'b1; o.alu_src_b = SRCB_REGB; o.alu_op = ALU_FUNCT; end
      R_WB:      begin o.reg_dst = 1'b1; o.reg_write = 1'b1; end
      MEM_ADDR:  begin o.alu_src_a = 1'b1; o.alu_src_b = SRCB_IMM; o.alu_op = ALU_ADD; end
      MEM_READ:  o.iord = 1'b1;
      MEM_WB:    begin o.mem_to_reg = 1'b1; o.reg_write = 1'b1; end
      MEM_WRITE: begin o.iord = 1'b1; o.mem_write = 1'b1; end
      BRANCH:    begin o.alu_src_a = 1'b1; o.alu_src_b = SRCB_REGB; o.alu_op = ALU_SUB;
                       o.pc_write_cond = 1'b1; o.pc_source = PCSRC_ALUOUT; end
      JUMP:      begin o.pc_write = 1'b1; o.pc_source = PCSRC_JUMP; end
      ADDI_EXEC: begin o.alu_src_a = 1'b1; o.alu_src_b = SRCB_IMM; o.alu_op = ALU_ADD; end
      ADDI_WB:   o.reg_write = 1'b1;
`ifdef CTRL_EXCEPTION_EN
      ILLEGAL:   begin o.epc_write = 1'b1; o.pc_write = 1'b1; o.pc_source = PCSRC_EXC; end
`endif
      default:   o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/ctrl_wait_counter.sv
// Cycle counter for memory wait states; done when count equals the requested last value.
// Latency: load takes effect on the next edge; done is combinational from the count.
// Backpressure: none.
module ctrl_wait_counter
  import ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              en,
  input  logic [WAIT_W-1:0] last,
  output logic              done
);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  // Restart at zero on state entry, otherwise count while a wait state is active.
  always_comb begin
    cnt_d = cnt_q;
    if (load)    cnt_d = '0;
    else if (en) cnt_d = cnt_q + 1'b1;
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign done = (cnt_q == last);

endmodule

// File: rtl/control_unit.sv
// Multicycle Moore control FSM for the MIPS subset (fetch/decode/execute); optional CTRL_EXCEPTION_EN.
// Latency: outputs registered from next state, valid the cycle the state is entered.
// Backpressure: none; memory waits are fixed at MEM_WAIT_CYCLES extra cycles.
module control_unit
  import ctrl_pkg::*;
#(
  parameter int MEM_WAIT_CYCLES = 1
) (
  input  logic       clock,
  input  logic       r_l,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
`ifdef CTRL_EXCEPTION_EN
  output logic       EPCWrite,
`endif
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       RegWrite,
  output logic       AluSourceA,
  output logic [1:0] AluSourceB,
  output logic [1:0] AluOP,
  output logic [1:0] PCSource
);

  // Read waits leave after MEM_WAIT_CYCLES cycles; a write holds for one more.
  localparam logic [WAIT_W-1:0] WAIT_LAST_RD = WAIT_W'(MEM_WAIT_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST_WR = WAIT_W'(MEM_WAIT_CYCLES);

  state_t    state_q, state_d;
  ctrl_out_t out_q, out_d;
  logic      mem_sw_q, mem_sw_d;
  logic      wait_load, wait_en, wait_done;
  logic [WAIT_W-1:0] wait_last;

  assign wait_load = (state_d != state_q);
  assign wait_en   = (state_q == FETCH_WAIT) || (state_q == MEM_WAIT) || (state_q == MEM_WRITE);
  assign wait_last = (state_q == MEM_WRITE) ? WAIT_LAST_WR : WAIT_LAST_RD;

  ctrl_wait_counter u_wait (
    .clk  (clock),
    .rst  (r_l),
    .load (wait_load),
    .en   (wait_en),
    .last (wait_last),
    .done (wait_done)
  );

  // Next-state sequencing; the lw/sw choice is captured in DECODE with the dispatch.
  always_comb begin
    state_d  = state_q;
    mem_sw_d = mem_sw_q;
    case (state_q)
      RESET:      state_d = FETCH;
      FETCH:      state_d = (MEM_WAIT_CYCLES == 0) ? IR_LOAD : FETCH_WAIT;
      FETCH_WAIT: if (wait_done) state_d = IR_LOAD;
      IR_LOAD:    state_d = DECODE;
      DECODE: begin
        mem_sw_d = (opcode == OP_SW);
        case (opcode)
          OP_RTYPE:     state_d = R_EXEC;
          OP_LW, OP_SW: state_d = MEM_ADDR;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = ADDI_EXEC;
          default:      state_d = ILLEGAL;
        endcase
      end
      R_EXEC:     state_d = R_WB;
      MEM_ADDR:   state_d = mem_sw_q ? MEM_WRITE : MEM_READ;
      MEM_READ:   state_d = (MEM_WAIT_CYCLES == 0) ? MEM_WB : MEM_WAIT;
      MEM_WAIT:   if (wait_done) state_d = MEM_WB;
      MEM_WRITE:  if (wait_done) state_d = FETCH;
      ADDI_EXEC:  state_d = ADDI_WB;
      R_WB, MEM_WB, BRANCH, JUMP, ADDI_WB, ILLEGAL: state_d = FETCH;
      default:    state_d = RESET;
    endcase
    out_d = state_outputs(state_d);
  end

  // State and registered Moore outputs; reset drops any write in flight.
  always_ff @(posedge clock) begin
    if (r_l) begin
      state_q  <= RESET;
      out_q    <= '0;
      mem_sw_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      mem_sw_q <= mem_sw_d;
    end
  end

  assign PCWrite     = out_q.pc_write;
  assign PCWriteCond = out_q.pc_write_cond;
  assign IorD        = out_q.iord;
  assign MemWrite    = out_q.mem_write;
  assign IRWrite     = out_q.ir_write;
  assign RegDst      = out_q.reg_dst;
  assign MemToReg    = out_q.mem_to_reg;
  assign RegWrite    = out_q.reg_write;
  assign AluSourceA  = out_q.alu_src_a;
  assign AluSourceB  = out_q.alu_src_b;
  assign AluOP       = out_q.alu_op;
  assign PCSource    = out_q.pc_source;

  // funct is decoded by ALU control and zero gates PCWriteCond in the datapath.
  logic unused_ok;
`ifdef CTRL_EXCEPTION_EN
  assign EPCWrite  = out_q.epc_write;
  assign unused_ok = ^{funct, zero};
`else
  assign unused_ok = ^{funct, zero, out_q.epc_write};
`endif

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: per-cycle expected output vectors queued per instruction.
// Latency: checks outputs #1 after each rising edge.
// Backpressure: none; every drain loop is cycle-bounded.
module tb_control_unit;

  localparam int S_FETCH = 1,  S_FW = 2,    S_IRL = 3,  S_DEC = 4,   S_REXE = 5;
  localparam int S_RWB = 6,    S_MADDR = 7, S_MREAD = 8, S_MWAIT = 9, S_MWB = 10;
  localparam int S_MWR = 11,   S_BR = 12,   S_J = 13,   S_AEXE = 14, S_AWB = 15, S_ILL = 16;

  logic       clock = 1'b0;
  logic       r_l = 1'b1, r_l3 = 1'b1;
  logic [5:0] opcode = '0, opcode3 = '0, funct = '0;
  logic       zero = 1'b0;

  logic pcw, pcwc, iord, memw, irw, regdst, m2r, regw, srca;
  logic [1:0] srcb, aluop, pcsrc;
  logic pcw3, pcwc3, iord3, memw3, irw3, regdst3, m2r3, regw3, srca3;
  logic [1:0] srcb3, aluop3, pcsrc3;
  logic epc, epc3;
  logic [15:0] obs, obs3;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_q3[$];

  always #5 clock = ~clock;

  control_unit dut (
    .clock(clock), .r_l(r_l), .opcode(opcode), .funct(funct), .zero(zero),
`ifdef CTRL_EXCEPTION_EN
    .EPCWrite(epc),
`endif
    .PCWrite(pcw), .PCWriteCond(pcwc), .IorD(iord), .MemWrite(memw), .IRWrite(irw),
    .RegDst(regdst), .MemToReg(m2r), .RegWrite(regw), .AluSourceA(srca),
    .AluSourceB(srcb), .AluOP(aluop), .PCSource(pcsrc)
  );

  control_unit #(.MEM_WAIT_CYCLES(3)) dut3 (
    .clock(clock), .r_l(r_l3), .opcode(opcode3), .funct(funct), .zero(zero),
`ifdef CTRL_EXCEPTION_EN
    .EPCWrite(epc3),
`endif
    .PCWrite(pcw3), .PCWriteCond(pcwc3), .IorD(iord3), .MemWrite(memw3), .IRWrite(irw3),
    .RegDst(regdst3), .MemToReg(m2r3), .RegWrite(regw3), .AluSourceA(srca3),
    .AluSourceB(srcb3), .AluOP(aluop3), .PCSource(pcsrc3)
  );

`ifndef CTRL_EXCEPTION_EN
  assign epc  = 1'b0;
  assign epc3 = 1'b0;
`endif

  // Vector: [15]EPC [14]PCW [13]PCWC [12]IorD [11]MemW [10]IRW [9]RegDst [8]M2R [7]RegW
  //         [6]SrcA [5:4]SrcB [3:2]AluOP [1:0]PCSource
  assign obs  = {epc, pcw, pcwc, iord, memw, irw, regdst, m2r, regw, srca, srcb, aluop, pcsrc};
  assign obs3 = {epc3, pcw3, pcwc3, iord3, memw3, irw3, regdst3, m2r3, regw3, srca3,
                 srcb3, aluop3, pcsrc3};

  function automatic logic [15:0] exp_out(input int st);
    logic [15:0] v;
    v = '0;
    case (st)
      S_FETCH: v[5:4] = 2'b01;
      S_IRL:   begin v[10] = 1'b1; v[14] = 1'b1; v[5:4] = 2'b01; end
      S_DEC:   v[5:4] = 2'b11;
      S_REXE:  begin v[6] = 1'b1; v[3:2] = 2'b10; end
      S_RWB:   begin v[9] = 1'b1; v[7] = 1'b1; end
      S_MADDR: begin v[6] = 1'b1; v[5:4] = 2'b10; end
      S_MREAD: v[12] = 1'b1;
      S_MWB:   begin v[8] = 1'b1; v[7] = 1'b1; end
      S_MWR:   begin v[12] = 1'b1; v[11] = 1'b1; end
      S_BR:    begin v[6] = 1'b1; v[3:2] = 2'b01; v[13] = 1'b1; v[1:0] = 2'b01; end
      S_J:     begin v[14] = 1'b1; v[1:0] = 2'b10; end
      S_AEXE:  begin v[6] = 1'b1; v[5:4] = 2'b10; end
      S_AWB:   v[7] = 1'b1;
`ifdef CTRL_EXCEPTION_EN
      S_ILL:   begin v[15] = 1'b1; v[14] = 1'b1; v[1:0] = 2'b11; end
`endif
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic push_st(input bit use3, input int st);
    if (use3) exp_q3.push_back(exp_out(st));
    else      exp_q.push_back(exp_out(st));
  endtask

  // Queue the per-cycle expected outputs of one instruction, FETCH through its last state.
  task automatic push_instr(input bit use3, input logic [5:0] op, input int mwc);
    push_st(use3, S_FETCH);
    for (int i = 0; i < mwc; i++) push_st(use3, S_FW);
    push_st(use3, S_IRL);
    push_st(use3, S_DEC);
    case (op)
      6'b000000: begin push_st(use3, S_REXE); push_st(use3, S_RWB); end
      6'b100011: begin
        push_st(use3, S_MADDR); push_st(use3, S_MREAD);
        for (int i = 0; i < mwc; i++) push_st(use3, S_MWAIT);
        push_st(use3, S_MWB);
      end
      6'b101011: begin
        push_st(use3, S_MADDR);
        for (int i = 0; i < mwc + 1; i++) push_st(use3, S_MWR);
      end
      6'b000100: push_st(use3, S_BR);
      6'b000010: push_st(use3, S_J);
      6'b001000: begin push_st(use3, S_AEXE); push_st(use3, S_AWB); end
      default:   push_st(use3, S_ILL);
    endcase
  endtask

  // Pop and compare one expected vector per cycle; report length and strobe counts.
  task automatic drain(input bit use3, input string tag, output int n, output int nrw,
                       output int nmw, output int last_rw);
    logic [15:0] e, o;
    n = 0; nrw = 0; nmw = 0; last_rw = -1;
    while ((use3 ? exp_q3.size() : exp_q.size()) > 0) begin
      if (n >= 64) begin
        errors++; checks++;
        $display("FAIL %s drain_timeout: got %0d cycles, required under 64", tag, n);
        if (use3) exp_q3.delete(); else exp_q.delete();
        break;
      end
      e = use3 ? exp_q3.pop_front() : exp_q.pop_front();
      o = use3 ? obs3 : obs;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s cycle%0d: got %h required %h", tag, n + 1, o, e);
      end
      if (o[7] === 1'b1) begin nrw++; last_rw = n; end
      if (o[11] === 1'b1) nmw++;
      n++;
      tick();
    end
  endtask

  task automatic check_fetch(input bit use3, input string tag);
    logic [15:0] o;
    o = use3 ? obs3 : obs;
    checks++;
    if (o !== exp_out(S_FETCH)) begin
      errors++;
      $display("FAIL %s back_to_fetch: got %h required %h", tag, o, exp_out(S_FETCH));
    end
  endtask

  task automatic test_reset;
    r_l = 1'b1; r_l3 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (obs !== 16'h0) begin errors++; $display("FAIL reset_out: got %h required 0000", obs); end
      checks++;
      if (obs3 !== 16'h0) begin errors++; $display("FAIL reset_out3: got %h required 0000", obs3); end
    end
    r_l = 1'b0;
    tick();
    check_fetch(1'b0, "reset_release");
  endtask

  task automatic test_rtype;
    int n, nrw, nmw, lrw;
    opcode = 6'b000000; funct = 6'b100000;
    push_instr(1'b0, opcode, 1);
    drain(1'b0, "rtype", n, nrw, nmw, lrw);
    checks++;
    if (n !== 6 || nrw !== 1 || lrw !== 5) begin
      errors++;
      $display("FAIL rtype_shape: got len=%0d regwrites=%0d at=%0d required 6/1/5", n, nrw, lrw);
    end
    check_fetch(1'b0, "rtype");
  endtask

  task automatic test_branch;
    int n, nrw, nmw, lrw;
    opcode = 6'b000100;
    for (int z = 1; z >= 0; z--) begin
      zero = z[0];
      push_instr(1'b0, opcode, 1);
      drain(1'b0, "beq", n, nrw, nmw, lrw);
      checks++;
      if (n !== 5) begin errors++; $display("FAIL beq_len zero=%0d: got %0d required 5", z, n); end
      check_fetch(1'b0, "beq");
    end
  endtask

  task automatic test_sw;
    int n, nrw, nmw, lrw;
    opcode = 6'b101011;
    push_instr(1'b0, opcode, 1);
    drain(1'b0, "sw", n, nrw, nmw, lrw);
    checks++;
    if (nmw !== 2 || nrw !== 0) begin
      errors++;
      $display("FAIL sw_strobes: got memwrite=%0d regwrite=%0d required 2/0", nmw, nrw);
    end
    check_fetch(1'b0, "sw");
  endtask

  task automatic test_back_to_back;
    int n, nrw, nmw, lrw;
    logic [5:0] ops [3];
    int lens [3];
    ops[0] = 6'b000010; ops[1] = 6'b001000; ops[2] = 6'b100011;
    lens[0] = 5; lens[1] = 6; lens[2] = 8;
    for (int k = 0; k < 3; k++) begin
      opcode = ops[k];
      push_instr(1'b0, opcode, 1);
      drain(1'b0, "b2b", n, nrw, nmw, lrw);
      checks++;
      if (n !== lens[k]) begin
        errors++;
        $display("FAIL b2b_len op=%b: got %0d required %0d", ops[k], n, lens[k]);
      end
    end
    check_fetch(1'b0, "b2b");
  endtask

  task automatic test_illegal;
    int n, nrw, nmw, lrw;
    opcode = 6'b111111;
    push_instr(1'b0, opcode, 1);
    drain(1'b0, "illegal", n, nrw, nmw, lrw);
    check_fetch(1'b0, "illegal");
  endtask

  task automatic test_reset_mid_sw;
    int n, nrw, nmw, lrw;
    opcode = 6'b101011;
    push_st(1'b0, S_FETCH); push_st(1'b0, S_FW); push_st(1'b0, S_IRL);
    push_st(1'b0, S_DEC); push_st(1'b0, S_MADDR);
    drain(1'b0, "sw_rst", n, nrw, nmw, lrw);
    checks++;
    if (obs !== exp_out(S_MWR)) begin
      errors++; $display("FAIL sw_rst_in_write: got %h required %h", obs, exp_out(S_MWR));
    end
    r_l = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== 16'h0) begin
        errors++; $display("FAIL sw_rst_dropped cycle%0d: got %h required 0000", i + 1, obs);
      end
    end
    r_l = 1'b0;
    tick();
    check_fetch(1'b0, "sw_rst");
  endtask

  task automatic test_lw_wait3;
    int n, nrw, nmw, lrw;
    logic m2r_last;
    opcode3 = 6'b100011;
    r_l3 = 1'b0;
    tick();
    push_instr(1'b1, opcode3, 3);
    m2r_last = 1'b0;
    drain(1'b1, "lw3", n, nrw, nmw, lrw);
    checks++;
    if (n !== 12 || nrw !== 1 || lrw !== 11) begin
      errors++;
      $display("FAIL lw3_shape: got len=%0d regwrites=%0d at=%0d required 12/1/11", n, nrw, lrw);
    end
    check_fetch(1'b1, "lw3");
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_branch();
    test_sw();
    test_back_to_back();
    test_illegal();
    test_reset_mid_sw();
    test_lw_wait3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
